// File: rtl/reg_select_pipe_decoder.sv
// reg_select_pipe_decoder: pipelined LEGv8 register-field decoder with writeback delay chain and load-use flag
module reg_select_pipe_decoder #(
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31,
  parameter int WB_DELAY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ibus,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  output logic [NREGS-1:0] Aselect,
  output logic [NREGS-1:0] Bselect,
  output logic [NREGS-1:0] Dselect,
  output logic             imm_sel,
  output logic             out_valid,
  output logic [NREGS-1:0] wb_Dselect,
  output logic             wb_valid,
  output logic             load_use
);
  localparam int IW = 3 * NREGS + 3;
  localparam int CW = WB_DELAY * NREGS;
  logic             is_b, is_cb, is_ld, is_st, is_i, use_a, use_b, use_d, is_load;
  logic [4:0]       b_idx;
  logic [NREGS-1:0] dec_a, dec_b, dec_d;
  logic [IW-1:0]    dec_v, ix_d, ix_q;
  logic [WB_DELAY-1:0] wv_d, wv_q;
  logic [CW-1:0]    wd_d, wd_q;
  logic             unused_imm;
  assign unused_imm = ^ibus[15:10];
  assign is_b  = ibus[31:26] == 6'b000101;
  assign is_cb = !is_b && ibus[31:25] == 7'b1011010;
  assign is_ld = !is_b && !is_cb && ibus[31:21] == 11'b11111000010;
  assign is_st = !is_b && !is_cb && ibus[31:21] == 11'b11111000000;
  assign is_i  = !(is_b || is_cb || is_ld || is_st) && ibus[28:26] == 3'b100;
  assign use_a = !(is_b || is_cb);
  assign use_b = is_cb || is_st || !(is_b || is_ld || is_i);
  assign use_d = is_ld || is_i || !(is_b || is_cb || is_st);
  assign b_idx = (is_cb || is_st) ? ibus[4:0] : ibus[20:16];
  assign dec_a = use_a ? (NREGS'(1) << ibus[9:5]) : '0;
  assign dec_b = use_b ? (NREGS'(1) << b_idx) : '0;
  assign dec_d = (use_d && ibus[4:0] != 5'(ZERO_REG)) ? (NREGS'(1) << ibus[4:0]) : '0;
  assign dec_v = in_valid ? {dec_a, dec_b, dec_d, is_ld || is_st || is_i, 1'b1, is_ld} : '0;
  assign {Aselect, Bselect, Dselect, imm_sel, out_valid, is_load} = ix_q;
  assign wb_valid   = wv_q[WB_DELAY-1];
  assign wb_Dselect = wd_q[CW-1 -: NREGS];
  assign load_use   = out_valid && is_load && in_valid && |(Dselect & (dec_a | dec_b));
  // next state: flush bubbles ID/EX, stall holds it; the chain shifts every edge and takes a bubble on stall
  always_comb begin
    ix_d = flush ? '0 : stall ? ix_q : dec_v;
    wv_d = (wv_q << 1) | WB_DELAY'(out_valid && !stall);
    wd_d = (wd_q << NREGS) | CW'({NREGS{!stall}} & Dselect);
  end
  // ID/EX register and writeback chain with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ix_q <= '0;
      wv_q <= '0;
      wd_q <= '0;
    end else begin
      ix_q <= ix_d;
      wv_q <= wv_d;
      wd_q <= wd_d;
    end
  end
endmodule

// File: tb/tb_reg_select_pipe_decoder.sv
// tb_reg_select_pipe_decoder: directed plus random checks against a behavioural decoder and queue-based writeback model
module tb_reg_select_pipe_decoder;
  localparam int N = 32;
  localparam int Z = 31;
  localparam int W = 3;
  localparam logic [31:0] ADD3  = 32'h8B020023;
  localparam logic [31:0] ADD6  = 32'h8B0200A6;
  localparam logic [31:0] LDUR5 = 32'hF8400025;
  localparam logic [31:0] STUR7 = 32'hF8000047;
  localparam logic [31:0] ADDZ  = 32'h8B02003F;
  localparam logic [31:0] BR    = 32'h14000010;
  logic clk = 1'b0;
  logic reset, in_valid, stall, flush;
  logic [31:0] ibus;
  logic [N-1:0] Aselect, Bselect, Dselect, wb_Dselect;
  logic imm_sel, out_valid, wb_valid, load_use;
  int nchk = 0;
  int nerr = 0;
  logic [N-1:0] m_a, m_b, m_d;
  logic m_imm, m_v, m_ld;
  logic [N:0] chain[$];
  always #5 clk = ~clk;
  reg_select_pipe_decoder #(.NREGS(N), .ZERO_REG(Z), .WB_DELAY(W)) dut (
    .clk(clk), .reset(reset), .ibus(ibus), .in_valid(in_valid), .stall(stall), .flush(flush),
    .Aselect(Aselect), .Bselect(Bselect), .Dselect(Dselect), .imm_sel(imm_sel), .out_valid(out_valid),
    .wb_Dselect(wb_Dselect), .wb_valid(wb_valid), .load_use(load_use)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  function automatic logic [N-1:0] oh(input logic [4:0] i);
    logic [N-1:0] r;
    r = '0;
    if (int'(i) < N) r[i] = 1'b1;
    return r;
  endfunction
  function automatic void dec(input logic [31:0] ib, output logic [N-1:0] a, output logic [N-1:0] b,
                              output logic [N-1:0] d, output logic imm, output logic ld);
    logic [4:0] rt, rn, rm;
    rt = ib[4:0];
    rn = ib[9:5];
    rm = ib[20:16];
    a = '0; b = '0; d = '0; imm = 1'b0; ld = 1'b0;
    if (ib[31:26] == 6'b000101) begin
    end else if (ib[31:25] == 7'b1011010) begin
      b = oh(rt);
    end else if (ib[31:21] == 11'b11111000010) begin
      a = oh(rn); d = (rt == Z) ? '0 : oh(rt); imm = 1'b1; ld = 1'b1;
    end else if (ib[31:21] == 11'b11111000000) begin
      a = oh(rn); b = oh(rt); imm = 1'b1;
    end else if (ib[28:26] == 3'b100) begin
      a = oh(rn); d = (rt == Z) ? '0 : oh(rt); imm = 1'b1;
    end else begin
      a = oh(rn); b = oh(rm); d = (rt == Z) ? '0 : oh(rt);
    end
  endfunction
  task automatic clear_model();
    m_a = '0; m_b = '0; m_d = '0; m_imm = 0; m_v = 0; m_ld = 0;
    chain.delete();
    for (int i = 0; i < W; i++) chain.push_back('0);
  endtask
  task automatic step(input logic [31:0] ib, input logic iv, input logic st, input logic fl, input logic rs);
    logic [N-1:0] da, db, dd;
    logic di, dl;
    ibus = ib; in_valid = iv; stall = st; flush = fl; reset = rs;
    #1;
    dec(ib, da, db, dd, di, dl);
    chk("load_use", load_use, m_v && m_ld && iv && ((m_d & (da | db)) != '0));
    @(posedge clk);
    if (rs) clear_model();
    else begin
      chain.push_front(st ? '0 : {m_v, m_d});
      void'(chain.pop_back());
      if (fl) begin
        m_a = '0; m_b = '0; m_d = '0; m_imm = 0; m_v = 0; m_ld = 0;
      end else if (!st) begin
        if (iv) begin
          m_a = da; m_b = db; m_d = dd; m_imm = di; m_v = 1; m_ld = dl;
        end else begin
          m_a = '0; m_b = '0; m_d = '0; m_imm = 0; m_v = 0; m_ld = 0;
        end
      end
    end
    @(negedge clk);
    chk("Aselect", Aselect, m_a);
    chk("Bselect", Bselect, m_b);
    chk("Dselect", Dselect, m_d);
    chk("imm_sel", imm_sel, m_imm);
    chk("out_valid", out_valid, m_v);
    chk("wb_Dselect", wb_Dselect, chain[W-1][N-1:0]);
    chk("wb_valid", wb_valid, chain[W-1][N]);
  endtask
  function automatic logic [4:0] rr();
    return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
  endfunction
  function automatic logic [31:0] rnd_ins();
    logic [31:0] x;
    x = $urandom;
    x[4:0] = rr();
    x[9:5] = rr();
    x[20:16] = rr();
    case ($urandom_range(0, 5))
      0: x[31:26] = 6'b000101;
      1: x[31:25] = 7'b1011010;
      2: x[31:21] = 11'b11111000010;
      3: x[31:21] = 11'b11111000000;
      4: x[28:26] = 3'b100;
      default: ;
    endcase
    return x;
  endfunction
  initial begin
    reset = 1; ibus = '0; in_valid = 0; stall = 0; flush = 0;
    clear_model();
    @(negedge clk);
    step('0, 0, 0, 0, 1);
    step('0, 0, 0, 0, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    step(ADD3, 1, 0, 0, 0);
    chk("add_A", Aselect, 32'h2);
    chk("add_B", Bselect, 32'h4);
    chk("add_D", Dselect, 32'h8);
    for (int i = 0; i < 3; i++) step('0, 0, 0, 0, 0);
    chk("add_wbD", wb_Dselect, 32'h8);
    chk("add_wbv", wb_valid, 1);
    step(LDUR5, 1, 0, 0, 0);
    chk("ldur_D", Dselect, 32'h20);
    chk("ldur_imm", imm_sel, 1);
    ibus = ADD6; in_valid = 1; #1;
    chk("lu_hit", load_use, 1);
    ibus = ADD3; #1;
    chk("lu_miss", load_use, 0);
    step(ADD6, 1, 0, 0, 0);
    step(STUR7, 1, 0, 0, 0);
    chk("stur_B", Bselect, 32'h80);
    step(ADDZ, 1, 0, 0, 0);
    chk("xzr_D", Dselect, 0);
    step(BR, 1, 0, 0, 0);
    chk("b_valid", out_valid, 1);
    step(ADD3, 1, 0, 0, 0);
    step(STUR7, 1, 1, 0, 0);
    step(LDUR5, 1, 1, 0, 0);
    chk("stall_hold_D", Dselect, 32'h8);
    for (int i = 0; i < 4; i++) step('0, 0, 0, 0, 0);
    step(ADD3, 1, 0, 0, 0);
    step(ADD6, 1, 0, 0, 0);
    step(STUR7, 1, 1, 1, 0);
    chk("flush_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) step('0, 0, 0, 0, 0);
    step(ADD3, 1, 0, 0, 0);
    step(ADD6, 1, 0, 0, 0);
    step(ADD3, 1, 0, 0, 0);
    step(ADD6, 1, 0, 0, 1);
    chk("rst_mid_wbv", wb_valid, 0);
    chk("rst_mid_A", Aselect, 0);
    for (int i = 0; i < 600; i++)
      step(rnd_ins(), $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
